// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: field widths and
// active-high segment patterns, bit order {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned PWM_W = 4;

  localparam logic [PWM_W-1:0] PWM_FULL = 4'hF;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F   = 7'h71;

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_scan_driver_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_c_o
);

  // Pattern lookup; every code is covered, default keeps the block latch-free
  always_comb begin
    seg_c_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_c_o = SEG_0;
      4'h1: seg_c_o = SEG_1;
      4'h2: seg_c_o = SEG_2;
      4'h3: seg_c_o = SEG_3;
      4'h4: seg_c_o = SEG_4;
      4'h5: seg_c_o = SEG_5;
      4'h6: seg_c_o = SEG_6;
      4'h7: seg_c_o = SEG_7;
      4'h8: seg_c_o = SEG_8;
      4'h9: seg_c_o = SEG_9;
      4'hA: seg_c_o = SEG_A;
      4'hB: seg_c_o = SEG_B;
      4'hC: seg_c_o = SEG_C;
      4'hD: seg_c_o = SEG_D;
      4'hE: seg_c_o = SEG_E;
      4'hF: seg_c_o = SEG_F;
      default: seg_c_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with tear-free frame
// updates, leading-zero blanking, per-digit decimal point and PWM dimming.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned GUARD       = 2,
  parameter bit          AN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_GRD  = PRESC_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  // XOR masks turning internal active-high values into pin levels
  localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{AN_ACT_LOW}};
  localparam logic [SEG_W-1:0]  SEG_IDLE = {SEG_W{SEG_ACT_LOW}};

  logic [PRESC_W-1:0]             presc_q, presc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [PWM_W-1:0]               pwm_q, pwm_d;
  logic [DIGITS-1:0][NIB_W-1:0]   pend_q, pend_d;
  logic [DIGITS-1:0]              pdp_q, pdp_d;
  logic                           pend_v_q, pend_v_d;
  logic [DIGITS-1:0][NIB_W-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]              ddp_q, ddp_d;
  logic [DIGITS-1:0]              an_q, an_d;
  logic [SEG_W-1:0]               seg_q, seg_d;
  logic                           dp_q, dp_d;
  logic                           frame_done_q, frame_done_d;

  logic                           tick_c;
  logic                           wrap_c;
  logic                           lit_c;
  logic                           blank_c;
  logic [DIGITS-1:0]              nz_above_c;
  logic [DIGITS-1:0]              an_act_c;
  logic [SEG_W-1:0]               seg_dec_c;
  logic [SEG_W-1:0]               seg_on_c;

  // Slot timing: last prescaler count ends the slot, last digit's slot ends the frame
  always_comb begin
    tick_c = (presc_q == PRESC_LAST);
    wrap_c = tick_c && (idx_q == IDX_LAST);
  end

  // Prefix-OR from the top digit down: bit i set when any nibble i..DIGITS-1 is non-zero
  always_comb begin
    nz_above_c = '0;
    nz_above_c[DIGITS-1] = |disp_q[DIGITS-1];
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      nz_above_c[i] = nz_above_c[i+1] | (|disp_q[i]);
    end
  end

  seg_scan_driver_hex_decode u_hex_decode (
    .nibble_i (disp_q[idx_q]),
    .seg_c_o  (seg_dec_c)
  );

  // Digit gating: blanking, brightness PWM and the anti-ghosting guard window
  always_comb begin
    blank_c  = blank_lz && (idx_q != '0) && !nz_above_c[idx_q];
    seg_on_c = blank_c ? SEG_OFF : seg_dec_c;
    lit_c    = (brightness == PWM_FULL) || (pwm_q < brightness);
    an_act_c = '0;
    if (lit_c && (presc_q >= PRESC_GRD)) begin
      an_act_c = DIGITS'(1) << idx_q;
    end
  end

  // Next-state: counters, pending/display buffers (commit only at frame wrap), output regs
  always_comb begin
    presc_d      = tick_c ? '0 : presc_q + PRESC_W'(1);
    idx_d        = idx_q;
    pwm_d        = pwm_q + PWM_W'(1);
    pend_d       = pend_q;
    pdp_d        = pdp_q;
    pend_v_d     = pend_v_q;
    disp_d       = disp_q;
    ddp_d        = ddp_q;
    an_d         = an_act_c ^ AN_IDLE;
    seg_d        = seg_on_c ^ SEG_IDLE;
    dp_d         = ddp_q[idx_q] ^ SEG_ACT_LOW;
    frame_done_d = wrap_c;

    if (tick_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (wrap_c) begin
      // A load coinciding with the wrap goes straight to the display
      if (load) begin
        disp_d   = data;
        ddp_d    = dp_in;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        ddp_d    = pdp_q;
        pend_v_d = 1'b0;
      end
    end else if (load) begin
      pend_d   = data;
      pdp_d    = dp_in;
      pend_v_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pend_q       <= '0;
      pdp_q        <= '0;
      pend_v_q     <= 1'b0;
      disp_q       <= '0;
      ddp_q        <= '0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      dp_q         <= SEG_ACT_LOW;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pend_q       <= pend_d;
      pdp_q        <= pdp_d;
      pend_v_q     <= pend_v_d;
      disp_q       <= disp_d;
      ddp_q        <= ddp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
